mem_access_unit: RTL and testbench

// - MEM-stage load/store initiator that drives the byte-addressed, big-endian data memory.
// - Takes one request at a time from the pipeline over a valid/ready handshake.
// - Issues the memory strobes: mem_rena, mem_wena, mem_store_select, mem_addr, mem_data_in.
// - Captures the registered read word and sign/zero-extends it for LB/LBU/LH/LHU/LW.
// - Holds the pipeline via stall until the response is consumed.

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and data-memory strobes of the MEM-stage load/store unit.
// master: the access unit; slave: pipeline plus data memory on the other side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic        mem_rena;
    logic        mem_wena;
    logic [2:0]  mem_store_select;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err, stall,
               mem_rena, mem_wena, mem_store_select, mem_addr, mem_data_in
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall,
               mem_rena, mem_wena, mem_store_select, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a big-endian, byte-addressed data memory.
// Define ACCESS_CHECK_EN to reject misaligned and out-of-range accesses with resp_err.
module mem_access_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int unsigned MEM_BYTES = 1024
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_unit_if.master bus
);
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t      state, state_next;
    logic [2:0]  op_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [31:0] rdata_p1;
    logic        err_p1;
    logic        is_store;
    logic        access_err;

    function automatic logic [2:0] size_of(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] store_select(input logic [2:0] op);
        case (op)
            OP_SB:   return 3'b001;
            OP_SH:   return 3'b010;
            OP_SW:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // The addressed byte always arrives in mem_data_out[31:24]; halfwords occupy [31:16].
    function automatic logic [31:0] extract(input logic [2:0] op, input logic [31:0] word);
        case (op)
            OP_LB:   return {{24{word[31]}}, word[31:24]};
            OP_LBU:  return {24'h000000, word[31:24]};
            OP_LH:   return {{16{word[31]}}, word[31:16]};
            OP_LHU:  return {16'h0000, word[31:16]};
            default: return word;
        endcase
    endfunction

    function automatic logic access_bad(input logic [2:0] op, input logic [31:0] addr);
        logic [2:0]  sz;
        logic        misaligned;
        logic [32:0] end_addr;
        sz         = size_of(op);
        misaligned = (sz == 3'd2 && addr[0]) || (sz == 3'd4 && addr[1:0] != 2'b00);
        end_addr   = {1'b0, addr} + {30'd0, sz};
        return misaligned || (addr < BASE_ADDR) || (end_addr > LIMIT);
    endfunction

    assign is_store = op_p0[2] & (op_p0[1:0] != 2'b00);

`ifdef ACCESS_CHECK_EN
    assign access_err = access_bad(op_p0, addr_p0);
`else
    assign access_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next           = state;
        bus.req_ready        = 1'b0;
        bus.resp_valid       = 1'b0;
        bus.mem_rena         = 1'b0;
        bus.mem_wena         = 1'b0;
        bus.mem_store_select = 3'b000;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (access_err) begin
                    state_next = S_DONE;
                end else if (is_store) begin
                    bus.mem_wena         = 1'b1;
                    bus.mem_store_select = store_select(op_p0);
                    state_next           = S_DONE;
                end else begin
                    bus.mem_rena = 1'b1;
                    state_next   = S_WAIT;
                end
            end
            S_WAIT: state_next = S_DONE;
            S_DONE: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // p0: request captured on accept; p1: response formed in ISSUE (store/error) or WAIT (load)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p0    <= 3'b000;
            addr_p0  <= 32'h0;
            wdata_p0 <= 32'h0;
            rdata_p1 <= 32'h0;
            err_p1   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_p0    <= bus.req_op;
                        addr_p0  <= bus.req_addr;
                        wdata_p0 <= bus.req_wdata;
                    end
                end
                S_ISSUE: begin
                    err_p1 <= access_err;
                    if (access_err || is_store) rdata_p1 <= 32'h0;
                end
                S_WAIT:  rdata_p1 <= extract(op_p0, bus.mem_data_out);
                default: ;
            endcase
        end
    end

    assign bus.stall       = (state != S_IDLE);
    assign bus.mem_addr    = addr_p0;
    assign bus.mem_data_in = wdata_p0;
    assign bus.resp_rdata  = rdata_p1;
    assign bus.resp_err    = err_p1;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural big-endian memory, byte-level reference model,
// directed scenarios followed by randomized loads/stores.
module tb_mem_access_unit;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3;
    localparam logic [2:0] LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic clk = 1'b0;
    logic rst_n;
    logic fill;
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0]  dev_mem [1024];
    logic [7:0]  ref_mem [1024];
    int          rena_cnt = 0, wena_cnt = 0, bad_strobe = 0;
    logic [2:0]  last_wsel;
    logic [31:0] last_waddr, last_wdata, last_raddr;

    mem_access_unit_if bus();

    mem_access_unit #(.BASE_ADDR(BASE), .MEM_BYTES(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int didx(input logic [31:0] addr, input int k);
        return int'((addr - BASE + 32'(k)) & 32'h3FF);
    endfunction

    function automatic int size_of(input logic [2:0] op);
        int sizes [8] = '{1, 1, 2, 2, 4, 1, 2, 4};
        return sizes[op];
    endfunction

    // Data memory: registered read of the four bytes starting at mem_addr.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) dev_mem[i] <= 8'((i * 37 + 11) & 255);
        end else begin
            if (bus.mem_rena)
                bus.mem_data_out <= {dev_mem[didx(bus.mem_addr, 0)], dev_mem[didx(bus.mem_addr, 1)],
                                     dev_mem[didx(bus.mem_addr, 2)], dev_mem[didx(bus.mem_addr, 3)]};
            if (bus.mem_wena) begin
                case (bus.mem_store_select)
                    3'b001: dev_mem[didx(bus.mem_addr, 0)] <= bus.mem_data_in[7:0];
                    3'b010: begin
                        dev_mem[didx(bus.mem_addr, 0)] <= bus.mem_data_in[15:8];
                        dev_mem[didx(bus.mem_addr, 1)] <= bus.mem_data_in[7:0];
                    end
                    3'b100: begin
                        dev_mem[didx(bus.mem_addr, 0)] <= bus.mem_data_in[31:24];
                        dev_mem[didx(bus.mem_addr, 1)] <= bus.mem_data_in[23:16];
                        dev_mem[didx(bus.mem_addr, 2)] <= bus.mem_data_in[15:8];
                        dev_mem[didx(bus.mem_addr, 3)] <= bus.mem_data_in[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mem_rena) begin
            rena_cnt   <= rena_cnt + 1;
            last_raddr <= bus.mem_addr;
        end
        if (bus.mem_wena) begin
            wena_cnt   <= wena_cnt + 1;
            last_wsel  <= bus.mem_store_select;
            last_waddr <= bus.mem_addr;
            last_wdata <= bus.mem_data_in;
        end
        if ((bus.mem_store_select != 3'b000 && !bus.mem_wena) || (bus.mem_rena && bus.mem_wena))
            bad_strobe <= bad_strobe + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: applies a request to the byte array and yields the architectural result.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err);
        int     sz;
        longint val;
        sz  = size_of(op);
        err = 1'b0;
        rd  = 32'h0;
`ifdef ACCESS_CHECK_EN
        if ((longint'(addr) % sz) != 0 || longint'(addr) < longint'(BASE) ||
            longint'(addr) + sz > longint'(BASE) + 1024)
            err = 1'b1;
`endif
        if (!err) begin
            if (op >= SB) begin
                for (int k = 0; k < sz; k++)
                    ref_mem[didx(addr, k)] = 8'((wdata >> (8 * (sz - 1 - k))) & 32'hFF);
            end else begin
                val = 0;
                for (int k = 0; k < sz; k++) val = val * 256 + longint'(ref_mem[didx(addr, k)]);
                if ((op == LB || op == LH) && val >= (longint'(1) << (8 * sz - 1)))
                    val = val - (longint'(1) << (8 * sz));
                rd = 32'(val);
            end
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd);
        logic [31:0] exp_rd, mask;
        logic        exp_err, st;
        int          lat, rd0, wr0, sz;
        model(op, addr, wdata, exp_rd, exp_err);
        st   = (op >= SB);
        sz   = size_of(op);
        mask = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        rd0  = rena_cnt;
        wr0  = wena_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op = 3'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
        wait_resp(lat);
        rd = bus.resp_rdata;
        check("latency", 32'(lat), (st || exp_err) ? 32'd2 : 32'd3);
        check("rdata", rd, exp_rd);
        check("resp_err", 32'(bus.resp_err), 32'(exp_err));
        check("stall_done", 32'(bus.stall), 32'd1);
        check("rena_pulses", 32'(rena_cnt - rd0), (!st && !exp_err) ? 32'd1 : 32'd0);
        check("wena_pulses", 32'(wena_cnt - wr0), (st && !exp_err) ? 32'd1 : 32'd0);
        if (st && !exp_err) begin
            check("store_sel", 32'(last_wsel), 32'(sz));
            check("store_addr", last_waddr, addr);
            check("store_data", last_wdata & mask, wdata & mask);
        end else if (!exp_err) begin
            check("load_addr", last_raddr, addr);
        end
        @(posedge clk); #1;
        check("ready_after", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, exp_rd, off;
        logic        exp_err;
        logic [2:0]  op;
        int          lat, rd0, wr0, diffs, sz;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);
        rst_n = 1'b0; fill = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_strobes", {29'd0, bus.mem_rena, bus.mem_wena, 1'b0} | 32'(bus.mem_store_select), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_data_in", bus.mem_data_in, 32'h0);
        check("rst_resp", {bus.resp_rdata[30:0], bus.resp_err}, 32'h0);
        @(negedge clk);
        fill = 1'b0; rst_n = 1'b1;

        txn(SW, BASE, 32'h1122_3344, rd);
        txn(LW, BASE, 32'h0, rd);
        check("lw_word", rd, 32'h1122_3344);
        txn(LB, BASE + 32'd3, 32'h0, rd);
        check("lb_low_byte", rd, 32'h0000_0044);
        txn(SB, BASE + 32'h10, 32'h0000_0080, rd);
        txn(LB, BASE + 32'h10, 32'h0, rd);
        check("lb_sext", rd, 32'hFFFF_FF80);
        txn(LBU, BASE + 32'h10, 32'h0, rd);
        check("lbu_zext", rd, 32'h0000_0080);
        txn(SH, BASE + 32'h20, 32'h0000_BEEF, rd);
        txn(LH, BASE + 32'h20, 32'h0, rd);
        check("lh_sext", rd, 32'hFFFF_BEEF);
        txn(LHU, BASE + 32'h20, 32'h0, rd);
        check("lhu_zext", rd, 32'h0000_BEEF);

        // Response held back for five cycles while a competing request is presented.
        model(LW, BASE, 32'h0, exp_rd, exp_err);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_op = LW; bus.req_addr = BASE;
        @(posedge clk); #1;
        bus.req_op = SW; bus.req_addr = BASE + 32'h40; bus.req_wdata = 32'hCAFE_F00D;
        wait_resp(lat);
        check("hold_latency", 32'(lat), 32'd3);
        wr0 = wena_cnt;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_rdata", bus.resp_rdata, exp_rd);
            check("hold_stall", 32'(bus.stall), 32'd1);
            check("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        check("hold_no_issue", 32'(wena_cnt - wr0), 32'd0);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_idle", {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
        model(SW, BASE + 32'h40, 32'hCAFE_F00D, exp_rd, exp_err);
        @(posedge clk); #1;
        check("accept_after_release", 32'(bus.stall), 32'd1);
        bus.req_valid = 1'b0;
        wait_resp(lat);
        check("held_sw_latency", 32'(lat), 32'd2);
        check("held_sw_issued", 32'(wena_cnt - wr0), 32'd1);
        @(posedge clk); #1;
        txn(LW, BASE + 32'h40, 32'h0, rd);
        check("held_sw_readback", rd, 32'hCAFE_F00D);

        // Asynchronous reset while a load sits in WAIT.
        rd0 = rena_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = LW; bus.req_addr = BASE + 32'h8;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("wait_state_stall", {30'd0, bus.stall, bus.resp_valid}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(bus.req_ready), 32'd1);
        check("async_rst_quiet", {29'd0, bus.resp_valid, bus.stall, bus.mem_rena}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_resp", 32'(bus.resp_valid), 32'd0);
        check("rst_single_read", 32'(rena_cnt - rd0), 32'd1);
        diffs = 0;
        for (int i = 0; i < 1024; i++) if (dev_mem[i] !== ref_mem[i]) diffs++;
        check("mem_intact", 32'(diffs), 32'd0);

        // Misaligned / out-of-range accesses: rejected only with ACCESS_CHECK_EN.
        txn(LW, BASE + 32'd2, 32'h0, rd);
        txn(SW, BASE + 32'h3FE, 32'hDEAD_BEEF, rd);
        txn(LHU, BASE + 32'h3FF, 32'h0, rd);

        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            sz = size_of(op);
            if ($urandom_range(0, 3) != 0) off = 32'($urandom_range(0, 1024 / sz - 1) * sz);
            else                           off = 32'($urandom_range(0, 1020));
            txn(op, BASE + off, $urandom, rd);
        end

        diffs = 0;
        for (int i = 0; i < 1024; i++) if (dev_mem[i] !== ref_mem[i]) diffs++;
        check("mem_final", 32'(diffs), 32'd0);
        check("strobe_outside_issue", 32'(bad_strobe), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
